// File: rtl/soc_bus_arb.sv
// Round-robin arbiter sharing one soc_if slave port between NUM_MST masters, one whole
// transaction at a time. Define SOC_ARB_TIMEOUT_EN to enable the slave-response timeout.
module soc_bus_arb #(
    parameter int unsigned NUM_MST  = 2,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_RDAT = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_MST-1:0]      m_vld,
    input  logic [NUM_MST*4-1:0]    m_we,
    input  logic [NUM_MST*30-1:0]   m_addr,
    input  logic [NUM_MST*32-1:0]   m_wdat,
    output logic [NUM_MST-1:0]      m_rdy,
    output logic [31:0]             m_rdat,
    output logic                    s_vld,
    output logic [3:0]              s_we,
    output logic [29:0]             s_addr,
    output logic [31:0]             s_wdat,
    input  logic                    s_rdy,
    input  logic [31:0]             s_rdat,
    output logic [NUM_MST-1:0]      gnt,
    output logic                    err
);

    localparam int unsigned PtrW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    if (NUM_MST < 2 || NUM_MST > 8 || TIMEOUT < 2) begin : g_param_chk
        $error("soc_bus_arb: NUM_MST must be 2..8 and TIMEOUT at least 2");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state;
    logic [PtrW-1:0] rr_ptr;
    logic [PtrW-1:0] gidx;
    logic [PtrW-1:0] gidx_inc;
    logic [PtrW-1:0] pick_idx;
    logic            pick_vld;
    logic            busy;
    logic            cur_vld;
    logic            tmo;
    logic            done;

    assign busy     = (state == StBusy);
    assign cur_vld  = m_vld[gidx];
    assign gidx_inc = (gidx == PtrW'(NUM_MST - 1)) ? '0 : gidx + 1'b1;
    // Completion, abandoned request and timeout all release the bus the same way.
    assign done     = busy && (s_rdy || !cur_vld || tmo);

    // First requester at or after rr_ptr, wrapping modulo NUM_MST.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_MST) begin
                idx = idx - NUM_MST;
            end
            cand = PtrW'(idx);
            if (!pick_vld && m_vld[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            gnt    <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (pick_vld) begin
                        state <= StBusy;
                        gnt   <= NUM_MST'(1) << pick_idx;
                        gidx  <= pick_idx;
                    end
                end
                StBusy: begin
                    if (done) begin
                        state  <= StIdle;
                        gnt    <= '0;
                        rr_ptr <= gidx_inc;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] cnt;

    assign tmo = busy && cur_vld && !s_rdy && (cnt == CntW'(TIMEOUT - 1));

    // Held at zero while idle so every BUSY period starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            cnt <= '0;
        end else if (!s_rdy) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign err = tmo && !rst;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        s_we   = '0;
        s_addr = '0;
        s_wdat = '0;
        if (busy) begin
            for (int unsigned i = 0; i < NUM_MST; i++) begin
                if (gidx == PtrW'(i)) begin
                    s_we   = m_we[i*4 +: 4];
                    s_addr = m_addr[i*30 +: 30];
                    s_wdat = m_wdat[i*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        m_rdy = '0;
        if (busy && !rst && (s_rdy || tmo)) begin
            m_rdy[gidx] = 1'b1;
        end
    end

    assign s_vld  = busy && cur_vld && !rst && !tmo;
    assign m_rdat = tmo ? ERR_RDAT : s_rdat;

endmodule

// File: tb/tb_soc_bus_arb.sv
// Scoreboard bench for soc_bus_arb: directed requests push expected grants and completions,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_soc_bus_arb;

    localparam int N = 2;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_vld;
    logic [N*4-1:0]  m_we;
    logic [N*30-1:0] m_addr;
    logic [N*32-1:0] m_wdat;
    logic [N-1:0]    m_rdy;
    logic [31:0]     m_rdat;
    logic            s_vld;
    logic [3:0]      s_we;
    logic [29:0]     s_addr;
    logic [31:0]     s_wdat;
    logic            s_rdy;
    logic [31:0]     s_rdat;
    logic [N-1:0]    gnt;
    logic            err;

    logic        mv[N];
    logic [3:0]  mwe[N];
    logic [29:0] maddr[N];
    logic [31:0] mwdat[N];

    typedef struct {
        int          mst;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    int   gq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int waits = 0;
    int wcnt = 0;
    bit slave_en = 1'b1;
    bit gap_chk = 1'b0;
    int last_rdy_cyc = -1;
    int gnt_rise_cyc = 0;
    logic [N-1:0] prev_gnt = '0;

    soc_bus_arb #(
        .NUM_MST  (N),
        .TIMEOUT  (16),
        .ERR_RDAT (ERR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_vld  (m_vld),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdat (m_wdat),
        .m_rdy  (m_rdy),
        .m_rdat (m_rdat),
        .s_vld  (s_vld),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_wdat (s_wdat),
        .s_rdy  (s_rdy),
        .s_rdat (s_rdat),
        .gnt    (gnt),
        .err    (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_vld  = '0;
        m_we   = '0;
        m_addr = '0;
        m_wdat = '0;
        for (int i = 0; i < N; i++) begin
            m_vld[i]          = mv[i];
            m_we[i*4 +: 4]    = mwe[i];
            m_addr[i*30 +: 30] = maddr[i];
            m_wdat[i*32 +: 32] = mwdat[i];
        end
    end

    function automatic logic [31:0] rdat_fn(logic [29:0] a);
        return 32'h0234_5678 ^ {a, 2'b00};
    endfunction

    // Slave: answers after `waits` stall cycles while enabled.
    assign s_rdy  = s_vld && slave_en && (wcnt >= waits);
    assign s_rdat = rdat_fn(s_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!s_vld || s_rdy) wcnt <= 0;
        else                 wcnt <= wcnt + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic void exp_push(int m, logic [3:0] we, logic [29:0] a, logic [31:0] d,
                                     bit t);
        exp_t e;
        e.mst  = m;
        e.we   = we;
        e.addr = a;
        e.wdat = d;
        e.rdat = t ? ERR : rdat_fn(a);
        e.tmo  = t;
        sb.push_back(e);
    endfunction

    // Monitor: grant rises and completion strobes are compared against the queues.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (gnt != '0 && prev_gnt == '0) begin
                gnt_rise_cyc = cyc;
                if (gq.size() == 0) begin
                    fail("unexpected_gnt");
                end else begin
                    g = gq.pop_front();
                    check("gnt", 32'(gnt), 32'(1) << g);
                end
                if (gap_chk && last_rdy_cyc >= 0) check("idle_gap", cyc - last_rdy_cyc, 2);
            end
            prev_gnt = gnt;
            if (m_rdy != '0) begin
                last_rdy_cyc = cyc;
                if (sb.size() == 0) begin
                    fail("unexpected_m_rdy");
                end else begin
                    e = sb.pop_front();
                    check("m_rdy", 32'(m_rdy), 32'(1) << e.mst);
                    check("m_rdat", m_rdat, e.rdat);
                    if (e.tmo) begin
                        check("tmo_err", 32'(err), 1);
                        check("tmo_s_vld", 32'(s_vld), 0);
                        check("tmo_busy_cycles", cyc - gnt_rise_cyc, 15);
                    end else begin
                        check("err", 32'(err), 0);
                        check("s_vld", 32'(s_vld), 1);
                        check("s_we", 32'(s_we), 32'(e.we));
                        check("s_addr", 32'(s_addr), 32'(e.addr));
                        check("s_wdat", s_wdat, e.wdat);
                    end
                end
            end
        end
    end

    // Call just after a posedge; holds the request until m_rdy, then drops it next cycle.
    task automatic do_req(int m, logic [3:0] we, logic [29:0] a, logic [31:0] d);
        int n = 0;
        mv[m]    = 1'b1;
        mwe[m]   = we;
        maddr[m] = a;
        mwdat[m] = d;
        @(negedge clk);
        while (!m_rdy[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_rdy[m]) fail("rdy_wait");
        @(posedge clk);
        #1;
        mv[m] = 1'b0;
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (gnt == '0) fail("gnt_wait");
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mv[i]    = 1'b0;
            mwe[i]   = '0;
            maddr[i] = '0;
            mwdat[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_s_vld", 32'(s_vld), 0);
        check("rst_m_rdy", 32'(m_rdy), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_gnt", 32'(gnt), 0);

        // Single zero-wait read from master 0 (rr_ptr=0).
        gq.push_back(0);
        exp_push(0, 4'h0, 30'h0400_0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        fork
            do_req(0, 4'h0, 30'h0400_0000, 32'h0);
            begin
                @(negedge clk);
                check("lat_gnt_n", 32'(gnt), 0);
                check("lat_s_vld_n", 32'(s_vld), 0);
                @(negedge clk);
                check("lat_gnt_n1", 32'(gnt), 1);
            end
        join

        // Both masters write continuously, 2 wait states; rr_ptr=1 so master 1 leads.
        waits = 2;
        gap_chk = 1'b1;
        last_rdy_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(1);
            gq.push_back(0);
            exp_push(1, 4'b1100, 30'h200 + 30'(k), 32'hB000_0000 + k, 1'b0);
            exp_push(0, 4'hF, 30'h100 + 30'(k), 32'hA000_0000 + k, 1'b0);
        end
        @(posedge clk);
        #1;
        fork
            for (int k = 0; k < 4; k++) do_req(0, 4'hF, 30'h100 + 30'(k), 32'hA000_0000 + k);
            for (int k = 0; k < 4; k++) do_req(1, 4'b1100, 30'h200 + 30'(k), 32'hB000_0000 + k);
        join

        // Master 1 alone, back-to-back zero-wait writes.
        waits = 0;
        last_rdy_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            gq.push_back(1);
            exp_push(1, 4'b0011, 30'h300 + 30'(k), 32'hC0DE_0000 + k, 1'b0);
        end
        for (int k = 0; k < 3; k++) do_req(1, 4'b0011, 30'h300 + 30'(k), 32'hC0DE_0000 + k);
        gap_chk = 1'b0;

        // Reset while BUSY with the slave stalled; the held request is then served.
        slave_en = 1'b0;
        gq.push_back(0);
        gq.push_back(0);
        exp_push(0, 4'h0, 30'h3C, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        fork
            do_req(0, 4'h0, 30'h3C, 32'h0);
            begin
                wait_gnt();
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(negedge clk);
                check("mid_rst_s_vld", 32'(s_vld), 0);
                check("mid_rst_m_rdy", 32'(m_rdy), 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_gnt", 32'(gnt), 0);
                check("post_rst_s_vld", 32'(s_vld), 0);
                check("post_rst_m_rdy", 32'(m_rdy), 0);
                slave_en = 1'b1;
            end
        join

`ifdef SOC_ARB_TIMEOUT_EN
        // Silent slave: master 1 (rr_ptr=1) times out, then master 0 does.
        slave_en = 1'b0;
        gq.push_back(1);
        gq.push_back(0);
        exp_push(1, 4'h0, 30'h60, 32'h0, 1'b1);
        exp_push(0, 4'hF, 30'h50, 32'h5555_0000, 1'b1);
        @(posedge clk);
        #1;
        fork
            do_req(0, 4'hF, 30'h50, 32'h5555_0000);
            do_req(1, 4'h0, 30'h60, 32'h0);
        join
        slave_en = 1'b1;
`endif

        // Master 1 abandons after 2 BUSY cycles; rr_ptr must move on to master 0.
        slave_en = 1'b0;
        gq.push_back(1);
        @(posedge clk);
        #1;
        mv[1]    = 1'b1;
        mwe[1]   = 4'h0;
        maddr[1] = 30'h77;
        wait_gnt();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mv[1] = 1'b0;
        @(negedge clk);
        check("abandon_m_rdy", 32'(m_rdy), 0);
        check("abandon_s_vld", 32'(s_vld), 0);
        @(negedge clk);
        check("abandon_gnt", 32'(gnt), 0);
        slave_en = 1'b1;
        gq.push_back(0);
        gq.push_back(1);
        exp_push(0, 4'hF, 30'h400, 32'h1111_2222, 1'b0);
        exp_push(1, 4'h1, 30'h401, 32'h3333_4444, 1'b0);
        @(posedge clk);
        #1;
        fork
            do_req(0, 4'hF, 30'h400, 32'h1111_2222);
            do_req(1, 4'h1, 30'h401, 32'h3333_4444);
        join

        repeat (5) @(negedge clk);
        check("sb_left", 32'(sb.size()), 0);
        check("gq_left", 32'(gq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
